// File: rtl/sdr_16_port_arb.sv
// sdr_16_port_arb
//   Round-robin arbiter that shares one 16-bit SDR SDRAM control FSM between
//   NPORTS egress FIFOs. It also runs the periodic refresh timer. Refresh and
//   port grants are mutually exclusive: a pending refresh blocks new grants
//   but never pre-empts a transaction that is already in flight.
//
// Ports
//   sdram_clk     : clock, everything on the rising edge
//   sdram_rst     : synchronous active-high reset
//   port_req      : per-port egress FIFO non-empty
//   state_idle    : FSM is in IDLE
//   cmd_aref      : FSM auto-refresh pulse, acknowledges refresh_req
//   fifo_rd_adr   : FSM address-fetch strobe
//   fifo_rd_data  : FSM data-fetch strobe
//   fifo_empty    : muxed empty flag of the granted port (1 when no grant)
//   refresh_req   : refresh request to the FSM
//   grant         : registered one-hot grant, egress read-mux select
//   port_rd_adr   : fifo_rd_adr routed to the granted port
//   port_rd_data  : fifo_rd_data routed to the granted port
//   ref_overrun   : sticky, refresh interval expired with refresh still pending

module sdr_16_port_arb #(
    parameter int NPORTS     = 4,
    parameter int REF_CYCLES = 390
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic [NPORTS-1:0] port_req,
    input  logic              state_idle,
    input  logic              cmd_aref,
    input  logic              fifo_rd_adr,
    input  logic              fifo_rd_data,
    output logic              fifo_empty,
    output logic              refresh_req,
    output logic [NPORTS-1:0] grant,
    output logic [NPORTS-1:0] port_rd_adr,
    output logic [NPORTS-1:0] port_rd_data,
    output logic              ref_overrun
);

    localparam int IDX_W = $clog2(NPORTS);
    localparam int CNT_W = $clog2(REF_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NPORTS - 1);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_BUSY,
        ARB_REF
    } arb_state_e;

    arb_state_e        state_q, state_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ref_pend_q, ref_pend_d;
    logic              ref_overrun_q, ref_overrun_d;

    logic              expire;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;

    // Refresh timer. Expiry beats a simultaneous cmd_aref so a refresh that
    // falls due in the acknowledge cycle is not lost.
    always_comb begin
        expire        = (cnt_q == '0);
        cnt_d         = expire ? CNT_LOAD : (cnt_q - CNT_ONE);
        ref_pend_d    = ref_pend_q;
        if (expire) begin
            ref_pend_d = 1'b1;
        end else if (cmd_aref) begin
            ref_pend_d = 1'b0;
        end
        ref_overrun_d = ref_overrun_q | (expire & ref_pend_q);
    end

    // Round-robin winner: first requester searching upward from last+1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int i = 1; i <= NPORTS; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NPORTS);
            if (!win_found && port_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbiter next state. The IDLE refresh check includes this cycle's
    // expiry so a request arriving together with expiry is not granted.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (ref_pend_q || expire) begin
                    state_d = ARB_REF;
                end else if (win_found && state_idle) begin
                    state_d          = ARB_WAIT;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    idx_d            = win_idx;
                end
            end
            ARB_WAIT: begin
                if (!state_idle) begin
                    state_d = ARB_BUSY;
                end else if (!port_req[idx_q]) begin
                    // Withdrawn before the FSM started: last stays put so
                    // the same port keeps its turn.
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            ARB_BUSY: begin
                if (state_idle) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    last_d  = idx_q;
                end
            end
            ARB_REF: begin
                if (!ref_pend_q && state_idle) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            idx_q         <= '0;
            last_q        <= LAST_RST;
            cnt_q         <= CNT_LOAD;
            ref_pend_q    <= 1'b0;
            ref_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            ref_pend_q    <= ref_pend_d;
            ref_overrun_q <= ref_overrun_d;
        end
    end

    // refresh_req drops as soon as ref_pend clears, i.e. the cycle after
    // cmd_aref, even though ARB_REF lingers until the FSM is idle again.
    assign refresh_req  = (state_q == ARB_REF) & ref_pend_q;
    assign grant        = grant_q;
    assign fifo_empty   = ~|(port_req & grant_q);
    assign port_rd_adr  = grant_q & {NPORTS{fifo_rd_adr}};
    assign port_rd_data = grant_q & {NPORTS{fifo_rd_data}};
    assign ref_overrun  = ref_overrun_q;

endmodule

// File: tb/tb_sdr_16_port_arb.sv
module tb_sdr_16_port_arb;

    localparam int NP   = 4;
    localparam int REFC = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NP-1:0] port_req = '0;
    logic          state_idle = 1'b1;
    logic          cmd_aref = 1'b0;
    logic          fifo_rd_adr = 1'b0;
    logic          fifo_rd_data = 1'b0;
    logic          fifo_empty;
    logic          refresh_req;
    logic [NP-1:0] grant;
    logic [NP-1:0] port_rd_adr;
    logic [NP-1:0] port_rd_data;
    logic          ref_overrun;

    sdr_16_port_arb #(.NPORTS(NP), .REF_CYCLES(REFC)) dut (
        .sdram_clk    (clk),
        .sdram_rst    (rst),
        .port_req     (port_req),
        .state_idle   (state_idle),
        .cmd_aref     (cmd_aref),
        .fifo_rd_adr  (fifo_rd_adr),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .refresh_req  (refresh_req),
        .grant        (grant),
        .port_rd_adr  (port_rd_adr),
        .port_rd_data (port_rd_data),
        .ref_overrun  (ref_overrun)
    );

    always #5 clk = ~clk;

    // One record = inputs applied for one clock plus the outputs expected
    // just after that clock edge (with the same inputs still applied).
    typedef struct {
        string         name;
        bit            rst;
        bit [NP-1:0]   req;
        bit            idle;
        bit            aref;
        bit            rda;
        bit            rdd;
        bit [NP-1:0]   exp_grant;
        bit            exp_rreq;
        bit            exp_ovr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int total = 0;
    int bad   = 0;

    function automatic void add(string nm, bit r, bit [NP-1:0] rq, bit idl, bit ar,
                                bit ra, bit rd, bit [NP-1:0] eg, bit er, bit eo);
        vec_t v;
        v.name = nm; v.rst = r; v.req = rq; v.idle = idl; v.aref = ar;
        v.rda = ra; v.rdd = rd; v.exp_grant = eg; v.exp_rreq = er; v.exp_ovr = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0h want %0h", nm, fld, act, exp);
        end
    endtask

    // Scoreboard consumer: compares one expected record per clock.
    always @(posedge clk) begin
        vec_t e;
        logic [NP-1:0] ee_adr, ee_dat;
        logic          ee_emp;
        #1;
        if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            ee_emp = ~|(e.req & e.exp_grant);
            ee_adr = e.exp_grant & {NP{e.rda}};
            ee_dat = e.exp_grant & {NP{e.rdd}};
            check(e.name, "grant",        32'(grant),        32'(e.exp_grant));
            check(e.name, "refresh_req",  32'(refresh_req),  32'(e.exp_rreq));
            check(e.name, "ref_overrun",  32'(ref_overrun),  32'(e.exp_ovr));
            check(e.name, "fifo_empty",   32'(fifo_empty),   32'(ee_emp));
            check(e.name, "port_rd_adr",  32'(port_rd_adr),  32'(ee_adr));
            check(e.name, "port_rd_data", 32'(port_rd_data), 32'(ee_dat));
            check(e.name, "no_overlap",   32'(refresh_req && (grant != '0)), 32'(0));
        end
    end

    initial begin
        // ---- reset values (requests present must not leak through)
        add("rst0", 1, 4'b1111, 1, 0, 1, 1, 4'b0000, 0, 0);
        add("rst1", 1, 4'b1111, 1, 0, 1, 1, 4'b0000, 0, 0);

        // ---- single port
        add("sp_grant", 0, 4'b0100, 1, 0, 1, 0, 4'b0100, 0, 0);
        add("sp_adr",   0, 4'b0100, 0, 0, 1, 0, 4'b0100, 0, 0);
        add("sp_data",  0, 4'b0100, 0, 0, 0, 1, 4'b0100, 0, 0);
        add("sp_hold",  0, 4'b0000, 0, 0, 0, 0, 4'b0100, 0, 0);
        add("sp_rel",   0, 4'b0000, 1, 0, 1, 1, 4'b0000, 0, 0);
        add("sp_idle",  0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);

        // ---- round robin, 5 transactions
        add("rr_rst", 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        for (int t = 0; t < 5; t++) begin
            bit [NP-1:0] g;
            g = 4'b0001 << (t % NP);
            add("rr_grant", 0, 4'b1111, 1, 0, 0, 0, g,       0, 0);
            add("rr_busy",  0, 4'b1111, 0, 0, 1, 1, g,       0, 0);
            add("rr_gap",   0, 4'b1111, 1, 0, 0, 0, 4'b0000, 0, 0);
        end

        // ---- refresh expiry coincides with a new request
        add("rq_rst", 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= REFC - 1; k++)
            add("rq_fill", 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        add("rq_expire", 0, 4'b0001, 1, 0, 0, 0, 4'b0000, 1, 0);
        add("rq_pend",   0, 4'b0001, 1, 0, 0, 0, 4'b0000, 1, 0);
        add("rq_aref",   0, 4'b0001, 0, 1, 0, 0, 4'b0000, 0, 0);
        add("rq_fsmref", 0, 4'b0001, 0, 0, 0, 0, 4'b0000, 0, 0);
        add("rq_exit",   0, 4'b0001, 1, 0, 0, 0, 4'b0000, 0, 0);
        add("rq_grant",  0, 4'b0001, 1, 0, 0, 0, 4'b0001, 0, 0);

        // ---- refresh expires while busy
        add("rb_rst", 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= REFC - 3; k++)
            add("rb_fill", 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        add("rb_grant",  0, 4'b0010, 1, 0, 0, 0, 4'b0010, 0, 0);
        add("rb_busy",   0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0);
        add("rb_expire", 0, 4'b0010, 0, 0, 0, 1, 4'b0010, 0, 0);
        add("rb_busy2",  0, 4'b0010, 0, 0, 0, 0, 4'b0010, 0, 0);
        add("rb_rel",    0, 4'b0010, 1, 0, 0, 0, 4'b0000, 0, 0);
        add("rb_refreq", 0, 4'b0010, 1, 0, 0, 0, 4'b0000, 1, 0);
        add("rb_aref",   0, 4'b0010, 0, 1, 0, 0, 4'b0000, 0, 0);
        add("rb_exit",   0, 4'b0010, 1, 0, 0, 0, 4'b0000, 0, 0);
        add("rb_grant2", 0, 4'b0010, 1, 0, 0, 0, 4'b0010, 0, 0);

        // ---- request withdrawn in WAIT
        add("wd_rst",    1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        add("wd_grant",  0, 4'b0001, 1, 0, 0, 0, 4'b0001, 0, 0);
        add("wd_drop",   0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        add("wd_regrant",0, 4'b0011, 1, 0, 0, 0, 4'b0001, 0, 0);
        add("wd_busy",   0, 4'b0011, 0, 0, 0, 0, 4'b0001, 0, 0);
        add("wd_rel",    0, 4'b0011, 1, 0, 0, 0, 4'b0000, 0, 0);
        add("wd_next",   0, 4'b0011, 1, 0, 0, 0, 4'b0010, 0, 0);

        // ---- overrun (second expiry with refresh still pending), then reset mid-BUSY
        add("ov_rst", 1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        for (int k = 1; k <= REFC - 1; k++)
            add("ov_fill0", 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0);
        for (int k = REFC; k <= 2 * REFC - 1; k++)
            add("ov_pend", 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 0);
        add("ov_set",    0, 4'b0000, 1, 1, 0, 0, 4'b0000, 1, 1);
        add("ov_sticky", 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 1, 1);
        add("ov_aref",   0, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 1);
        add("ov_exit",   0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 1);
        add("ov_grant",  0, 4'b0100, 1, 0, 0, 0, 4'b0100, 0, 1);
        add("ov_busy",   0, 4'b0100, 0, 0, 1, 1, 4'b0100, 0, 1);
        add("ov_midrst", 1, 4'b0100, 0, 0, 1, 1, 4'b0000, 0, 0);
        add("ov_after",  0, 4'b0100, 1, 0, 0, 0, 4'b0100, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            port_req     = vecs[i].req;
            state_idle   = vecs[i].idle;
            cmd_aref     = vecs[i].aref;
            fifo_rd_adr  = vecs[i].rda;
            fifo_rd_data = vecs[i].rdd;
            exp_q.push_back(vecs[i]);
        end

        repeat (3) @(posedge clk);
        #2;
        check("drain", "pending", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
